// File: rtl/div_255_arb_pkg.sv
// Shared types and helpers for the divide-by-255 arbiter.
// Holds widths, the tag bundle and the round-robin picker.
package div_255_arb_pkg;

    localparam int DIV255_DIN_W = 16;
    localparam int DIV255_Q_W   = 9;
    localparam int TAG_ID_W     = 3;
    localparam int RR_MAX       = 8;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // One-hot pick of the first set req bit at or above ptr,
    // wrapping at n (n <= RR_MAX, ptr < n).
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] req,
        input logic [2:0]        ptr,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] g;
        logic              found;
        int unsigned       idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && req[idx[2:0]]) begin
                g[idx[2:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/div_255_arb_if.sv
// Requester / divider bundle for div_255_arb.
// slave: the arbiter side; master: requesters plus divider.
interface div_255_arb_if #(
    parameter int N_REQ = 4,
    parameter int DIN_W = 16,
    parameter int Q_W   = 9
);
    logic                   en;
    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ*DIN_W-1:0] req_dividend;
    logic [N_REQ-1:0]       req_rdy;
    logic                   div_in_vld;
    logic [DIN_W-1:0]       div_dividend;
    logic                   div_out_vld;
    logic [Q_W-1:0]         div_quotient;
    logic [N_REQ-1:0]       rsp_vld;
    logic [Q_W-1:0]         rsp_quotient;
    logic                   err_tag;
    logic                   err_clr;

    modport slave (
        input  en, req_vld, req_dividend,
        input  div_out_vld, div_quotient, err_clr,
        output req_rdy, div_in_vld, div_dividend,
        output rsp_vld, rsp_quotient, err_tag
    );

    modport master (
        output en, req_vld, req_dividend,
        output div_out_vld, div_quotient, err_clr,
        input  req_rdy, div_in_vld, div_dividend,
        input  rsp_vld, rsp_quotient, err_tag
    );
endinterface

// File: rtl/div_255_tag_pipe.sv
// Requester-ID shift pipe tracking work inside the divider.
// Ports: clk, rst (sync, flushes), i_tag in, o_tail out.
module div_255_tag_pipe
    import div_255_arb_pkg::*;
#(
    parameter int DIV_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t i_tag,
    output tag_t o_tail
);
    tag_t r_pipe [DIV_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIV_LAT; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < DIV_LAT; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_tail = r_pipe[DIV_LAT-1];
endmodule

// File: rtl/div_255_arb.sv
// Round-robin sharing of one divide-by-255 pipe among N_REQ requesters.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module div_255_arb
    import div_255_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DIN_W   = DIV255_DIN_W,
    parameter int Q_W     = DIV255_Q_W,
    parameter int DIV_LAT = 3,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input logic          clk,
    input logic          rst,
    div_255_arb_if.slave bus
);
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_issue_id;
    logic              r_div_in_vld;
    logic [DIN_W-1:0]  r_div_dividend;
    logic [N_REQ-1:0]  r_rsp_vld;
    logic [Q_W-1:0]    r_rsp_q;
    logic              r_err;

    logic [RR_MAX-1:0] w_req8;
    logic [RR_MAX-1:0] w_pick;
    logic [2:0]        w_ptr3;
    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_gid;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic              w_any;
    tag_t              w_tag_in;
    tag_t              w_tail;
    logic [ID_W-1:0]   w_tail_id;
    logic              w_hit;
    logic              w_mis;

    always_comb begin
        w_req8 = '0;
        w_req8[N_REQ-1:0] = bus.req_vld & {N_REQ{bus.en}};
        w_ptr3 = '0;
        w_ptr3[ID_W-1:0] = r_ptr;
        w_pick = rr_pick(w_req8, w_ptr3, N_REQ);
        w_gnt  = w_pick[N_REQ-1:0];
        w_gid  = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_gnt[i]) w_gid = ID_W'(i);
    end

    assign w_any = |w_gnt;
    // Explicit wrap keeps the pointer below N_REQ for non-power-of-two counts.
    assign w_ptr_nxt = (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + ID_W'(1);

    // Tag enters alongside the dividend the divider actually samples,
    // so the tail lines up with div_out_vld.
    always_comb begin
        w_tag_in = '0;
        w_tag_in.vld = r_div_in_vld;
        w_tag_in.id[ID_W-1:0] = r_issue_id;
    end

    div_255_tag_pipe #(
        .DIV_LAT (DIV_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_tag  (w_tag_in),
        .o_tail (w_tail)
    );

    assign w_tail_id = w_tail.id[ID_W-1:0];
    assign w_hit     = w_tail.vld & bus.div_out_vld;
    assign w_mis     = w_tail.vld ^ bus.div_out_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            r_issue_id     <= '0;
            r_div_in_vld   <= 1'b0;
            r_div_dividend <= '0;
            r_rsp_vld      <= '0;
            r_rsp_q        <= '0;
            r_err          <= 1'b0;
        end else begin
            r_div_in_vld <= w_any;
            if (w_any) begin
                r_ptr          <= w_ptr_nxt;
                r_issue_id     <= w_gid;
                r_div_dividend <= bus.req_dividend[w_gid*DIN_W +: DIN_W];
            end
            r_rsp_vld <= '0;
            if (w_hit) begin
                r_rsp_vld[w_tail_id] <= 1'b1;
                r_rsp_q              <= bus.div_quotient;
            end
            // A new misalignment beats a simultaneous clear.
            if (w_mis)
                r_err <= 1'b1;
            else if (bus.err_clr)
                r_err <= 1'b0;
        end
    end

    assign bus.req_rdy      = w_gnt;
    assign bus.div_in_vld   = r_div_in_vld;
    assign bus.div_dividend = r_div_dividend;
    assign bus.rsp_vld      = r_rsp_vld;
    assign bus.rsp_quotient = r_rsp_q;
    assign bus.err_tag      = r_err;
endmodule

// File: tb/tb_div_255_arb.sv
// Scoreboard bench for div_255_arb with a behavioural divider.
// Directed grants/quotients are queued; a negedge monitor checks them.
module tb_div_255_arb;
    import div_255_arb_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } dexp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  v;
        logic [8:0]  q;
    } rexp_t;

    logic clk = 1'b0;
    logic rst;
    logic inj;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [15:0] div_val [N];
    logic [8:0]  exp_q   [N];
    dexp_t       dq [$];
    rexp_t       rq [$];

    logic [LAT-1:0] m_v;
    logic [8:0]     m_q [LAT];

    div_255_arb_if #(.N_REQ(N), .DIN_W(16), .Q_W(9)) bus ();

    div_255_arb #(
        .N_REQ   (N),
        .DIN_W   (16),
        .Q_W     (9),
        .DIV_LAT (LAT),
        .ID_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in divider: LAT stages, shares the reset.
    always @(posedge clk) begin
        if (rst) begin
            m_v <= '0;
        end else begin
            m_v <= {m_v[LAT-2:0], bus.div_in_vld};
        end
        m_q[0] <= 9'(bus.div_dividend / 16'd255);
        for (int i = 1; i < LAT; i++) m_q[i] <= m_q[i-1];
    end

    assign bus.div_out_vld  = m_v[LAT-1] | inj;
    assign bus.div_quotient = m_q[LAT-1];

    always_comb begin
        bus.req_dividend = '0;
        for (int i = 0; i < N; i++)
            bus.req_dividend[i*16 +: 16] = div_val[i];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (bus.div_in_vld === 1'b1) begin
            if (dq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL div_in_unexpected: got dividend %0h expected none, cycle %0d",
                         bus.div_dividend, cyc);
            end else begin
                dexp_t e;
                e = dq.pop_front();
                chk("div_dividend", 32'(bus.div_dividend), 32'(e.d));
                chk("div_in_cycle", cyc, e.cyc);
            end
        end
        if (bus.rsp_vld !== 4'b0000) begin
            if (rq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rsp_unexpected: got rsp_vld %b expected none, cycle %0d",
                         bus.rsp_vld, cyc);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("rsp_vld", 32'(bus.rsp_vld), 32'(e.v));
                chk("rsp_quotient", 32'(bus.rsp_quotient), 32'(e.q));
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic e, input logic [3:0] g);
        bus.req_vld = v;
        bus.en      = e;
        #1;
        chk("req_rdy", 32'(bus.req_rdy), 32'(g));
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                dq.push_back('{cyc + 1, div_val[i]});
                rq.push_back('{cyc + LAT + 2, g, exp_q[i]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1, 4'b0000);
    endtask

    initial begin
        rst         = 1'b1;
        inj         = 1'b0;
        bus.en      = 1'b0;
        bus.req_vld = '0;
        bus.err_clr = 1'b0;
        div_val = '{16'd255, 16'd510, 16'd765, 16'd1020};
        exp_q   = '{9'd1, 9'd2, 9'd3, 9'd4};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_rdy", 32'(bus.req_rdy), 0);
        chk("rst_div_in_vld", 32'(bus.div_in_vld), 0);
        chk("rst_rsp_vld", 32'(bus.rsp_vld), 0);
        chk("rst_err_tag", 32'(bus.err_tag), 0);

        // All four requesting from pointer 0.
        for (int k = 0; k < 8; k++)
            step(4'b1111, 1'b1, 4'b0001 << (k % 4));
        idle(2);

        // Single request with the largest dividend.
        div_val[0] = 16'hFFFF;
        exp_q[0]   = 9'd257;
        step(4'b0001, 1'b1, 4'b0001);
        idle(6);

        // Pointer wrap from 3.
        step(4'b0100, 1'b1, 4'b0100);
        step(4'b1001, 1'b1, 4'b1000);
        step(4'b1001, 1'b1, 4'b0001);
        step(4'b1001, 1'b1, 4'b1000);
        step(4'b0010, 1'b1, 4'b0010);

        // Enable gating; pointer holds at 2.
        step(4'b1111, 1'b0, 4'b0000);
        step(4'b1111, 1'b0, 4'b0000);
        step(4'b1111, 1'b0, 4'b0000);
        step(4'b1111, 1'b1, 4'b0100);
        idle(6);

        // Reset with three in flight.
        step(4'b1111, 1'b1, 4'b1000);
        step(4'b1111, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 4'b0010);
        bus.req_vld = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dq.delete();
        rq.delete();
        chk("mid_rst_err_tag", 32'(bus.err_tag), 0);
        chk("mid_rst_div_in", 32'(bus.div_in_vld), 0);
        step(4'b1111, 1'b1, 4'b0001);
        idle(7);
        chk("mid_rst_err_after", 32'(bus.err_tag), 0);

        // Spurious divider output with an empty tag pipe.
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        chk("err_set", 32'(bus.err_tag), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_hold", 32'(bus.err_tag), 1);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        chk("err_clr", 32'(bus.err_tag), 0);
        inj = 1'b1;
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        bus.err_clr = 1'b0;
        chk("err_set_beats_clr", 32'(bus.err_tag), 1);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        chk("err_clr_again", 32'(bus.err_tag), 0);

        idle(8);
        chk("div_queue_drained", dq.size(), 0);
        chk("rsp_queue_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/div_255_arb.md
Name: div_255_arb

Overview:
- Round-robin arbiter and response router that shares one pipelined 16-bit divide-by-255 unit (ivc_div_255_16bit) among N_REQ requesters.
- The divider has a fixed latency and no backpressure. The block issues at most one dividend per cycle and tags each issue with its requester ID in a shift pipe that matches the divider latency.
- When the quotient emerges, the block returns it to the requester that issued it.
- The block sits between requester logic and the divider instance. It also flags any tag/valid misalignment.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DIN_W, 16, dividend width
- Q_W, 9, quotient width (65535/255 = 257 needs 9 bits)
- DIV_LAT, 3, cycles from div_in_vld to div_out_vld of the divider instance
- ID_W, $clog2(N_REQ), requester-ID width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  arbitration enable; 0 = no new grants, in-flight work completes
- req_vld  in  N_REQ  per-requester request valid
- req_dividend  in  N_REQ*DIN_W  per-requester dividend, requester i at [i*DIN_W +: DIN_W]
- req_rdy  out  N_REQ  one-hot grant / accept strobe
- div_in_vld  out  1  to divider data_in_vld
- div_dividend  out  DIN_W  to divider dividend_in
- div_out_vld  in  1  from divider data_out_vld
- div_quotient  in  Q_W  from divider quotient_out
- rsp_vld  out  N_REQ  one-hot response valid
- rsp_quotient  out  Q_W  quotient, shared by all requesters, qualified by rsp_vld
- err_tag  out  1  sticky misalignment flag
- err_clr  in  1  clears err_tag

Behaviour:
- Reset: all outputs 0; RR pointer = 0; tag pipe all invalid; err_tag = 0. Reset mid-operation flushes the tag pipe. Results already inside the divider are dropped. The divider must share the same reset.
- req_rdy is combinational from req_vld, en and the RR pointer. Handshake occurs when req_vld[i] & req_rdy[i]. A requester holds req_vld and its dividend stable until accepted. req_vld may drop without a handshake.
- Grant: the lowest index at or above the pointer, wrapping, among the asserted req_vld; only when en=1. At most one grant per cycle.
- Pointer update: after a grant to requester g, pointer = (g+1) mod N_REQ. With no grant, the pointer holds.
- Issue: on the handshake edge t, div_in_vld=1 and div_dividend=the granted dividend are registered, so both are visible in cycle t+1. Otherwise div_in_vld=0 and div_dividend holds its last value.
- Tag pipe: DIV_LAT stages of {vld, id}. It loads {1, g} in the same cycle div_in_vld is asserted.
- Response: when the tail stage is valid and div_out_vld=1, then rsp_vld[id]=1 and rsp_quotient=div_quotient. This output is registered, so rsp_vld appears at t+2+DIV_LAT relative to the request handshake edge t.
- Total latency is fixed: request accept to rsp_vld = DIV_LAT+2 cycles.
- Throughput: one request per cycle sustained. No response backpressure exists; requesters must always accept rsp_vld.
- Misalignment: if tail.vld != div_out_vld, err_tag is set.
  - rsp_vld is not asserted in that cycle.
  - err_tag stays at 1 until err_clr=1 or rst.
  - If a set condition and err_clr occur together, the set wins.
- en falling: grants stop in that cycle, the pipe drains normally, and the pointer holds.
- N_REQ not a power of two: the pointer wraps explicitly at N_REQ-1 and never takes values >= N_REQ.

Decomposition:
- Package div_255_arb_pkg:
  - constant DIV255_DIN_W=16
  - constant DIV255_Q_W=9
  - typedef tag_t struct {logic vld; logic [ID_W-1:0] id;}
  - function rr_pick(req, ptr) returning a one-hot grant, shared with the bench model
- Natural sub-module: div_255_tag_pipe, the DIV_LAT-deep tag shift register with flush on rst.
- The arbiter, issue register and response router stay in the top level.

Test Plan:
- Single request: N_REQ=4, DIV_LAT=3, req_vld=0001, dividend 0xFFFF at edge t. Expect div_in_vld at t+1 with 0xFFFF, then rsp_vld=0001 and rsp_quotient=257 at t+5.
- All requesting: req_vld=1111 held for 8 cycles, dividends 255*k with k = requester index + 1. Expect grant order 0,1,2,3,0,1,2,3 and quotients 1,2,3,4 routed to matching rsp_vld bits, with back-to-back div_in_vld.
- Pointer wrap: pointer=3, req_vld=1001. Expect grant to 3, then 0, then 3.
- en gating: en=0 with req_vld=1111. Expect req_rdy=0000 and no div_in_vld. After en returns to 1, arbitration resumes from the held pointer.
- Reset mid-flight: assert rst for 1 cycle while 3 requests are in flight. Expect no rsp_vld for them, err_tag=0 and pointer=0, and the next request completes normally.
- Error injection: force div_out_vld=1 with an empty tag pipe. Expect err_tag=1 next cycle, no rsp_vld, and err_tag held until err_clr pulses.
